four_digit_scanner: RTL and testbench

Time-multiplexed driver for the four-digit common-anode seven-segment display on the Spartan3 board. Holds a 16-bit value (four hex nibbles), cycles through the digits at a fixed refresh rate, and presents one nibble at a time on `char`. `char` feeds the existing 4-bit-to-segment decoder directly, and the scanner drives the matching active-low anode line. New values are applied only at frame boundaries, so a frame never shows a mix of old and new digits. A short all-anodes-off dead time at each digit change prevents ghosting.

---
 rtl/four_digit_scanner_pkg.sv | 21 ++
 rtl/four_digit_scanner_if.sv | 22 ++
 rtl/four_digit_scanner_refresh_counter.sv | 30 +++
 rtl/four_digit_scanner.sv | 96 +++++++++
 tb/tb_four_digit_scanner.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/four_digit_scanner_pkg.sv
// Shared constants and types for the seven-segment scanner.
package seg_pkg;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned NIBBLE_W = 4;
    localparam logic [3:0]  AN_OFF   = 4'b1111;

    typedef enum logic {
        SLOT_BLANK,
        SLOT_DRIVE
    } slot_t;

    // Bit d set means digit d is a leading zero and must stay dark.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [DIGITS*NIBBLE_W-1:0] v);
        lz_mask    = '0;
        lz_mask[3] = (v[15:12] == 4'h0);
        lz_mask[2] = (v[15:8]  == 8'h00);
        lz_mask[1] = (v[15:4]  == 12'h000);
    endfunction

endpackage

// File: rtl/four_digit_scanner_if.sv
// Load/display bundle between the value source and the scanner.
interface four_digit_scanner_if;

    logic                                         load;
    logic [seg_pkg::DIGITS*seg_pkg::NIBBLE_W-1:0] value;
    logic                                         blank_lz;
    logic [seg_pkg::NIBBLE_W-1:0]                 char;
    logic [seg_pkg::DIGITS-1:0]                   an;
    logic                                         pending;
    logic                                         frame_done;

    modport master (
        output load, value, blank_lz,
        input  char, an, pending, frame_done
    );

    modport slave (
        input  load, value, blank_lz,
        output char, an, pending, frame_done
    );

endinterface

// File: rtl/four_digit_scanner_refresh_counter.sv
// Slot timer: counts 0..CLK_DIV-1 and flags the wrap cycle.
module refresh_counter #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [$clog2(CLK_DIV)-1:0] cnt_next_o,
    output logic                       wrap_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and wrap strobe.
    always_comb begin
        wrap_o = (cnt_q == CW'(CLK_DIV - 1));
        cnt_d  = wrap_o ? '0 : cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/four_digit_scanner.sv
// Four-digit common-anode display scanner with frame-synchronous value updates.
module four_digit_scanner
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned DEAD_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    four_digit_scanner_if.slave  bus
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_d;
    logic          wrap;
    logic          boundary;
    slot_t         slot_d;
    logic [3:0]    blanked;

    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shown_q, shown_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic          pend_vld_q, pend_vld_d;

    logic [3:0]    char_q, char_d;
    logic [3:0]    an_q, an_d;
    logic          pending_q, pending_d;
    logic          frame_done_q, frame_done_d;

    refresh_counter #(.CLK_DIV(CLK_DIV)) u_refresh (
        .clk        (clk),
        .reset      (reset),
        .cnt_next_o (cnt_d),
        .wrap_o     (wrap)
    );

    // Digit index, displayed value and pending-load bookkeeping.
    always_comb begin
        boundary   = wrap && (idx_q == 2'd3);
        idx_d      = wrap ? idx_q + 2'd1 : idx_q;
        shown_d    = shown_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        if (boundary) begin
            // A load landing on the boundary edge bypasses the pending slot.
            pend_vld_d = 1'b0;
            if (bus.load)        shown_d = bus.value;
            else if (pend_vld_q) shown_d = pend_val_q;
        end else if (bus.load) begin
            pend_val_d = bus.value;
            pend_vld_d = 1'b1;
        end
    end

    // Registered outputs, derived from the post-edge state.
    always_comb begin
        slot_d       = (32'(cnt_d) < DEAD_CYCLES) ? SLOT_BLANK : SLOT_DRIVE;
        blanked      = bus.blank_lz ? lz_mask(shown_d) : '0;
        char_d       = shown_d[{idx_d, 2'b00} +: 4];
        an_d         = AN_OFF;
        if (slot_d == SLOT_DRIVE && !blanked[idx_d])
            an_d = ~(4'b0001 << idx_d);
        pending_d    = pend_vld_d;
        frame_done_d = boundary;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            shown_q      <= '0;
            pend_val_q   <= '0;
            pend_vld_q   <= 1'b0;
            char_q       <= '0;
            an_q         <= AN_OFF;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pend_val_q   <= pend_val_d;
            pend_vld_q   <= pend_vld_d;
            char_q       <= char_d;
            an_q         <= an_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.char       = char_q;
    assign bus.an         = an_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_four_digit_scanner.sv
// Scoreboard bench for four_digit_scanner with CLK_DIV=8, DEAD_CYCLES=2.
module tb_four_digit_scanner;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned DEAD    = 2;
    localparam int unsigned FRAME   = 4 * CLK_DIV;

    logic clk = 1'b0;
    logic reset;
    logic blz;

    always #5 clk = ~clk;

    four_digit_scanner_if bus();

    four_digit_scanner #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected {an, char, pending, frame_done} per edge.
    logic [9:0] sbq[$];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: time since reset determines slot and digit.
    int unsigned m_t;
    logic [15:0] m_shown, m_pval;
    logic        m_pvld;

    function automatic logic lead_zero(input logic [15:0] v, input int unsigned d);
        if (d == 0) return 1'b0;
        return ((v >> (4 * d)) == 16'h0);
    endfunction

    // Drive one edge's inputs, push the model's prediction, advance past the edge.
    task automatic cycle(input logic r, input logic l, input logic [15:0] v);
        logic [9:0]  e;
        int unsigned c, d;
        logic [3:0]  nib, an_e;
        logic        bnd;
        reset        = r;
        bus.load     = l;
        bus.value    = v;
        bus.blank_lz = blz;
        if (r) begin
            m_t = 0; m_shown = '0; m_pval = '0; m_pvld = 1'b0;
            e = {4'hF, 4'h0, 1'b0, 1'b0};
        end else begin
            m_t++;
            c   = m_t % CLK_DIV;
            d   = (m_t / CLK_DIV) % 4;
            bnd = ((m_t % FRAME) == 0);
            if (bnd) begin
                if (l)           m_shown = v;
                else if (m_pvld) m_shown = m_pval;
                m_pvld = 1'b0;
            end else if (l) begin
                m_pval = v;
                m_pvld = 1'b1;
            end
            nib  = 4'((m_shown >> (4 * d)) & 16'hF);
            an_e = 4'hF;
            if (c >= DEAD && !(blz && lead_zero(m_shown, d)))
                an_e = ~(4'b0001 << d);
            e = {an_e, nib, m_pvld, bnd};
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got, exp;
        blz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 16'h0);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp || got !== 10'b1111_0000_0_0)
                $display("FAIL reset_state cyc %0d: got %b want %b", k, got, exp);
            else n_pass++;
        end
        for (int e = 1; e <= 33; e++) begin
            cycle(1'b0, 1'b0, 16'h0);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL reset_idle edge %0d: got %b want %b", e, got, exp);
            else n_pass++;
            if (e == 31 || e == 32) begin
                n_chk++;
                if (bus.frame_done !== (e == 32))
                    $display("FAIL first_frame_done edge %0d: got %b want %b", e, bus.frame_done, (e == 32));
                else n_pass++;
            end
        end
    endtask

    task automatic test_load_display();
        logic [9:0] got, exp;
        blz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 16'h0);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL load_rst: got %b want %b", got, exp);
            else n_pass++;
        end
        for (int e = 1; e <= 64; e++) begin
            cycle(1'b0, (e == 4), 16'h12AB);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL load_display edge %0d: got %b want %b", e, got, exp);
            else n_pass++;
            if (e == 32) begin
                n_chk++;
                if ({bus.frame_done, bus.char, bus.an, bus.pending} !== {1'b1, 4'hB, 4'hF, 1'b0})
                    $display("FAIL load_boundary: got fd=%b char=%h an=%b pend=%b want fd=1 char=b an=1111 pend=0",
                             bus.frame_done, bus.char, bus.an, bus.pending);
                else n_pass++;
            end
            if (e == 36 || e == 44 || e == 52 || e == 60) begin
                n_chk++;
                if (bus.an !== ~(4'b0001 << ((e - 32) / 8)))
                    $display("FAIL load_anode edge %0d: got %b", e, bus.an);
                else n_pass++;
            end
        end
    endtask

    task automatic test_lz(input logic [15:0] val);
        logic [9:0] got, exp;
        blz = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 16'h0);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL lz_rst: got %b want %b", got, exp);
            else n_pass++;
        end
        for (int e = 1; e <= 64; e++) begin
            cycle(1'b0, (e == 5), val);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL lz_%h edge %0d: got %b want %b", val, e, got, exp);
            else n_pass++;
            if (e >= 33 && (e % 8) >= 2) begin
                n_chk++;
                if (bus.an !== ((e < 40) ? 4'b1110 : 4'b1111))
                    $display("FAIL lz_anode_%h edge %0d: got %b", val, e, bus.an);
                else n_pass++;
            end
        end
        blz = 1'b0;
    endtask

    task automatic test_last_wins();
        logic [9:0] got, exp;
        blz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 16'h0);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL last_rst: got %b want %b", got, exp);
            else n_pass++;
        end
        for (int e = 1; e <= 40; e++) begin
            cycle(1'b0, (e == 10 || e == 20), (e < 15) ? 16'h1111 : 16'h2222);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL last_wins edge %0d: got %b want %b", e, got, exp);
            else n_pass++;
            if (e == 32) begin
                n_chk++;
                if (bus.char !== 4'h2) $display("FAIL last_wins_char: got %h want 2", bus.char);
                else n_pass++;
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [9:0] got, exp;
        blz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 16'h0);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL bnd_rst: got %b want %b", got, exp);
            else n_pass++;
        end
        for (int e = 1; e <= 40; e++) begin
            cycle(1'b0, (e == 32), 16'h3333);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL boundary_load edge %0d: got %b want %b", e, got, exp);
            else n_pass++;
            if (e == 32 || e == 33) begin
                n_chk++;
                if ({bus.char, bus.pending} !== {4'h3, 1'b0})
                    $display("FAIL boundary_bypass edge %0d: got char=%h pend=%b want char=3 pend=0",
                             e, bus.char, bus.pending);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] got, exp;
        blz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 16'h0);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL midrst_rst: got %b want %b", got, exp);
            else n_pass++;
        end
        for (int e = 1; e <= 21; e++) begin
            cycle((e == 21), (e == 10), 16'h4444);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL mid_reset edge %0d: got %b want %b", e, got, exp);
            else n_pass++;
        end
        n_chk++;
        if ({bus.an, bus.char, bus.pending} !== {4'hF, 4'h0, 1'b0})
            $display("FAIL mid_reset_state: got an=%b char=%h pend=%b want an=1111 char=0 pend=0",
                     bus.an, bus.char, bus.pending);
        else n_pass++;
        for (int e = 1; e <= 36; e++) begin
            cycle(1'b0, 1'b0, 16'h0);
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL post_reset edge %0d: got %b want %b", e, got, exp);
            else n_pass++;
            if (e == 32) begin
                n_chk++;
                if ({bus.char, bus.frame_done} !== {4'h0, 1'b1})
                    $display("FAIL discarded_load: got char=%h fd=%b want char=0 fd=1", bus.char, bus.frame_done);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        logic       r, l;
        for (int e = 0; e < 400; e++) begin
            if ($urandom_range(0, 19) == 0) blz = ~blz;
            r = (e < 2) || ($urandom_range(0, 149) == 0);
            l = ($urandom_range(0, 9) == 0);
            cycle(r, l, 16'($urandom_range(0, 65535) & ((e % 3 == 0) ? 32'h00FF : 32'hFFFF)));
            got = {bus.an, bus.char, bus.pending, bus.frame_done};
            exp = sbq.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL random cyc %0d: got %b want %b", e, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        reset        = 1'b1;
        blz          = 1'b0;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.blank_lz = 1'b0;
        #1;
        test_reset();
        test_load_display();
        test_lz(16'h0005);
        test_lz(16'h0000);
        test_last_wins();
        test_boundary_load();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
